// File: rtl/riscv_core_pkg.sv
// Shared constants and helpers for the RISC-V core front end.
package riscv_core_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;

  // addi x0,x0,0 -- parked in IF/ID whenever it holds no real instruction
  localparam logic [INSTR_W-1:0] CANONICAL_NOP    = 32'h0000_0013;
  localparam logic [XLEN-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;

  // A fetch target must be word aligned; low bits set mean a bad target.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  // Force a byte address onto its containing word.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter: PC register, +4 incrementer and redirect/advance/hold mux.
module program_counter
  import riscv_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,             // synchronous, active-low
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target, // already word aligned
  input  logic            advance,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);

  logic [XLEN-1:0] pc_q, pc_d;

  // Wraps modulo 2^32 by construction of the fixed-width add.
  assign pc_plus4 = pc_q + XLEN'(PC_INC);
  assign pc       = pc_q;

  // Next-PC select: a redirect beats everything, then advance, else hold.
  always_comb begin
    // NOTE: assign a default first so every path drives pc_d and no latch is inferred.
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_target;
    end else if (advance) begin
      pc_d = pc_plus4;
    end
  end

  // PC register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the PC onto the instruction memory and
// captures the returned word into the IF/ID register for decode.
module fetch_stage
  import riscv_core_pkg::*;
#(
  parameter logic [XLEN-1:0]    RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = CANONICAL_NOP
) (
  input  logic               clk,
  input  logic               rst,            // synchronous, active-low
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               id_ready,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [XLEN-1:0]    if_id_pc,
  output logic [XLEN-1:0]    if_id_pc_plus4,
  output logic               misalign_err,
  output logic [31:0]        fetch_cnt
);

  logic [XLEN-1:0] pc, pc_plus4;
  logic            advance;

  logic               if_id_valid_q;
  logic [INSTR_W-1:0] if_id_instr_q;
  logic [XLEN-1:0]    if_id_pc_q, if_id_pc_plus4_q;
  logic               misalign_err_q;
  logic [31:0]        fetch_cnt_q;

  // The IF/ID slot can take a new word when it is empty or being consumed.
  // The valid bit doubles as the BUBBLE/VALID control state.
  assign advance = !if_id_valid_q || id_ready;

  program_counter #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_target (word_align(redirect_pc)),
    .advance         (advance),
    .pc              (pc),
    .pc_plus4        (pc_plus4)
  );

  // Memory is combinational, so the address is the live PC.
  assign imem_addr = pc;

  // IF/ID capture, flush on redirect, hold on stall; counter and error pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if_id_valid_q    <= 1'b0;
      if_id_instr_q    <= NOP_INSTR;
      if_id_pc_q       <= '0;
      if_id_pc_plus4_q <= '0;
      misalign_err_q   <= 1'b0;
      fetch_cnt_q      <= '0;
    end else if (redirect_valid) begin
      // Flush: the word fetched this cycle is on the wrong path.
      if_id_valid_q  <= 1'b0;
      if_id_instr_q  <= NOP_INSTR;
      misalign_err_q <= is_misaligned(redirect_pc);
    end else if (advance) begin
      if_id_valid_q    <= 1'b1;
      if_id_instr_q    <= imem_rdata;
      if_id_pc_q       <= pc;
      if_id_pc_plus4_q <= pc_plus4;
      misalign_err_q   <= 1'b0;
      fetch_cnt_q      <= fetch_cnt_q + 32'd1;
    end else begin
      // Stall: decode has not taken the current word, keep it intact.
      misalign_err_q <= 1'b0;
    end
  end

  assign if_id_valid    = if_id_valid_q;
  assign if_id_instr    = if_id_instr_q;
  assign if_id_pc       = if_id_pc_q;
  assign if_id_pc_plus4 = if_id_pc_plus4_q;
  assign misalign_err   = misalign_err_q;
  assign fetch_cnt      = fetch_cnt_q;

endmodule
